// File: rtl/seven_seg_capture_if.sv
// Multiplexed seven-segment bus (an/seg) plus the recovered-value outputs of the capture block.
// master drives the display bus; slave is the capture block snooping it.
interface seven_seg_capture_if;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        glyph_err;
  logic        anode_err;
  logic        stale;

  modport master (
    output an, seg,
    input  digits, digit_valid, frame_done, glyph_err, anode_err, stale
  );

  modport slave (
    input  an, seg,
    output digits, digit_valid, frame_done, glyph_err, anode_err, stale
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Snoops a scanned seven-segment bus and recovers the displayed 4-digit hex value,
// capturing each settled digit once, with frame/error pulses and a staleness timeout.
module seven_seg_capture #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input logic                clock,
  input logic                reset,
  seven_seg_capture_if.slave bus
);
  localparam int unsigned   CW   = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned   TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic {SETTLING, HELD} state_t;

  state_t        state;
  logic [3:0]    an_s1, an_s2, an_prev;
  logic [6:0]    seg_s1, seg_s2, seg_prev;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [15:0]   digits_q;
  logic [3:0]    valid_q, seen, seen_nxt;
  logic          frame_q, gerr_q, aerr_q, stale_q;
  logic          same, capture, one_low, blank, hex_hit, good;
  logic [3:0]    hex_val;
  logic [1:0]    idx;

  always_comb begin
    hex_hit = 1'b1;
    hex_val = '0;
    case (seg_s2)
      7'h40: hex_val = 4'h0;
      7'h79: hex_val = 4'h1;
      7'h24: hex_val = 4'h2;
      7'h30: hex_val = 4'h3;
      7'h19: hex_val = 4'h4;
      7'h12: hex_val = 4'h5;
      7'h02: hex_val = 4'h6;
      7'h78: hex_val = 4'h7;
      7'h00: hex_val = 4'h8;
      7'h10: hex_val = 4'h9;
      7'h08: hex_val = 4'hA;
      7'h03: hex_val = 4'hB;
      7'h46: hex_val = 4'hC;
      7'h21: hex_val = 4'hD;
      7'h06: hex_val = 4'hE;
      7'h0E: hex_val = 4'hF;
      default: hex_hit = 1'b0;
    endcase
  end

  // Capture fires on the edge where the stability count reaches its limit, so the
  // registered outputs move STABLE_CYCLES+2 edges after the bus settles.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (!an_s2[i]) idx = 2'(i);
    one_low  = $onehot(~an_s2);
    blank    = (seg_s2 == 7'h7F);
    same     = ({an_s2, seg_s2} == {an_prev, seg_prev});
    cnt_nxt  = !same ? CW'(1) : (cnt == CMAX) ? CMAX : cnt + 1'b1;
    tcnt_nxt = (tcnt == TMAX) ? TMAX : tcnt + 1'b1;
    capture  = (state == SETTLING) && (cnt_nxt == CMAX);
    good     = capture && one_low && (hex_hit || blank);
    seen_nxt = seen | (4'b0001 << idx);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      an_s1    <= 4'hF;
      an_s2    <= 4'hF;
      an_prev  <= 4'hF;
      seg_s1   <= 7'h7F;
      seg_s2   <= 7'h7F;
      seg_prev <= 7'h7F;
      cnt      <= '0;
      tcnt     <= '0;
      state    <= SETTLING;
      digits_q <= '0;
      valid_q  <= '0;
      seen     <= '0;
      frame_q  <= 1'b0;
      gerr_q   <= 1'b0;
      aerr_q   <= 1'b0;
      stale_q  <= 1'b0;
    end else begin
      an_s1    <= bus.an;
      an_s2    <= an_s1;
      an_prev  <= an_s2;
      seg_s1   <= bus.seg;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      cnt      <= cnt_nxt;
      frame_q  <= 1'b0;
      gerr_q   <= capture && one_low && !hex_hit && !blank;
      aerr_q   <= capture && !one_low && (an_s2 != 4'hF);

      case (state)
        SETTLING: if (capture) state <= HELD;
        HELD:     if (!same) state <= SETTLING;
        default:  state <= SETTLING;
      endcase

      // A good capture outranks a timeout landing on the same edge.
      if (good) begin
        tcnt    <= '0;
        stale_q <= 1'b0;
        if (hex_hit) begin
          digits_q[{idx, 2'b00} +: 4] <= hex_val;
          valid_q[idx]                <= 1'b1;
        end else begin
          valid_q[idx] <= 1'b0;
        end
        if (seen_nxt == 4'hF) begin
          seen    <= '0;
          frame_q <= 1'b1;
        end else begin
          seen <= seen_nxt;
        end
      end else begin
        tcnt <= tcnt_nxt;
        if (tcnt_nxt == TMAX) begin
          valid_q <= '0;
          seen    <= '0;
          stale_q <= 1'b1;
        end
      end
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.frame_done  = frame_q;
  assign bus.glyph_err   = gerr_q;
  assign bus.anode_err   = aerr_q;
  assign bus.stale       = stale_q;
endmodule
